// File: rtl/condition_sweep_checker.sv
// rtl/condition_sweep_checker.sv - sweep sel through 0..3 and check observed channels against a golden table
//
// Drives sel through 0..3 for ROUNDS passes. Each sel value is held for
// SETTLE_CYC cycles and then sampled for one CHECK cycle, where every enabled
// obs channel is compared with EXP_TABLE[2*sel+1:2*sel].
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a sweep (only honoured in IDLE)
//   sel        out  select driven to the logic under check
//   obs0..2    in   observed 2-bit results, combinational from sel
//   busy       out  sweep in progress (SETTLE or CHECK)
//   done       out  one-cycle end-of-sweep pulse
//   pass       out  last sweep had no mismatches, held until next start
//   err_cnt    out  mismatch count, saturating at 15
//   fail_vld   out  first failure captured
//   fail_sel   out  sel at the first failure
//   fail_ch    out  lowest failing channel at the first failure
module condition_sweep_checker #(
  parameter int         SETTLE_CYC = 2,
  parameter int         ROUNDS     = 2,
  parameter logic [7:0] EXP_TABLE  = 8'hE4,
  parameter logic [2:0] CH_MASK    = 3'b111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [1:0] sel,
  input  logic [1:0] obs0,
  input  logic [1:0] obs1,
  input  logic [1:0] obs2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic       fail_vld,
  output logic [1:0] fail_sel,
  output logic [1:0] fail_ch
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] LAST_STEP   = 4'(4 * ROUNDS - 1);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] step_q, step_d;
  logic [3:0] settle_q, settle_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic       fail_vld_q, fail_vld_d;
  logic [1:0] fail_sel_q, fail_sel_d;
  logic [1:0] fail_ch_q, fail_ch_d;
  logic       pass_q, pass_d;

  logic [1:0] exp_val;
  logic [2:0] mism;
  logic [1:0] mism_cnt;
  logic [4:0] err_sum;
  logic [3:0] err_next;
  logic [1:0] first_ch;

  always_comb begin
    exp_val  = EXP_TABLE[{sel_q, 1'b0} +: 2];
    mism     = CH_MASK & {obs2 != exp_val, obs1 != exp_val, obs0 != exp_val};
    mism_cnt = {1'b0, mism[0]} + {1'b0, mism[1]} + {1'b0, mism[2]};
    err_sum  = {1'b0, err_cnt_q} + {3'b000, mism_cnt};
    err_next = err_sum[4] ? 4'hF : err_sum[3:0];
    if (mism[0]) begin
      first_ch = 2'd0;
    end else if (mism[1]) begin
      first_ch = 2'd1;
    end else begin
      first_ch = 2'd2;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    step_d     = step_q;
    settle_d   = settle_q;
    err_cnt_d  = err_cnt_q;
    fail_vld_d = fail_vld_q;
    fail_sel_d = fail_sel_q;
    fail_ch_d  = fail_ch_q;
    pass_d     = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SETTLE;
          sel_d      = 2'd0;
          step_d     = 4'd0;
          settle_d   = SETTLE_LOAD;
          err_cnt_d  = 4'd0;
          fail_vld_d = 1'b0;
          fail_sel_d = 2'd0;
          fail_ch_d  = 2'd0;
          pass_d     = 1'b0;
        end
      end
      S_SETTLE: begin
        if (settle_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_CHECK: begin
        err_cnt_d = err_next;
        if ((mism != 3'b000) && !fail_vld_q) begin
          fail_vld_d = 1'b1;
          fail_sel_d = sel_q;
          fail_ch_d  = first_ch;
        end
        if (step_q == LAST_STEP) begin
          // Decide pass here so the final CHECK's mismatches are included and
          // pass is already valid during the DONE pulse.
          state_d = S_DONE;
          pass_d  = (err_next == 4'd0);
        end else begin
          state_d  = S_SETTLE;
          step_d   = step_q + 4'd1;
          sel_d    = sel_q + 2'd1;
          settle_d = SETTLE_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        sel_d   = 2'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= 2'd0;
      step_q     <= 4'd0;
      settle_q   <= 4'd0;
      err_cnt_q  <= 4'd0;
      fail_vld_q <= 1'b0;
      fail_sel_q <= 2'd0;
      fail_ch_q  <= 2'd0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      step_q     <= step_d;
      settle_q   <= settle_d;
      err_cnt_q  <= err_cnt_d;
      fail_vld_q <= fail_vld_d;
      fail_sel_q <= fail_sel_d;
      fail_ch_q  <= fail_ch_d;
      pass_q     <= pass_d;
    end
  end

  assign sel      = sel_q;
  assign busy     = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done     = (state_q == S_DONE);
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign fail_vld = fail_vld_q;
  assign fail_sel = fail_sel_q;
  assign fail_ch  = fail_ch_q;

endmodule

// File: tb/tb_condition_sweep_checker.sv
// tb/tb_condition_sweep_checker.sv - table-driven bench for condition_sweep_checker
module tb_condition_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start;
  int   mode;   // inst 0 stimulus: 0 identity, 1 obs1 stuck at 0, 2 all channels inverted
  bit   dly2;   // inst 2 stimulus: obs0 delayed by 2 cycles instead of 1

  logic [2:0] busy_v, done_v, pass_v, fvld_v;
  logic [1:0] sel_v  [3];
  logic [3:0] err_v  [3];
  logic [1:0] fsel_v [3];
  logic [1:0] fch_v  [3];

  logic [1:0] d_obs0, d_obs1, d_obs2;
  logic [1:0] m_obs0, m_obs1, m_obs2;
  logic [1:0] s_obs0, s_obs1, s_obs2;
  logic [1:0] dl1, dl2;

  assign d_obs0 = (mode == 2) ? ~sel_v[0] : sel_v[0];
  assign d_obs1 = (mode == 1) ? 2'd0 : ((mode == 2) ? ~sel_v[0] : sel_v[0]);
  assign d_obs2 = (mode == 2) ? ~sel_v[0] : sel_v[0];

  assign m_obs0 = sel_v[1];
  always @(negedge clk) begin
    m_obs1 <= 2'($urandom);
    m_obs2 <= 2'($urandom);
  end

  // Logic under check for the settle test: a delay line that idles at 3.
  always @(posedge clk) begin
    dl1 <= busy_v[2] ? sel_v[2] : 2'd3;
    dl2 <= dl1;
  end
  assign s_obs0 = dly2 ? dl2 : dl1;
  assign s_obs1 = sel_v[2];
  assign s_obs2 = sel_v[2];

  condition_sweep_checker u_def (
    .clk(clk), .rst(rst), .start(start), .sel(sel_v[0]),
    .obs0(d_obs0), .obs1(d_obs1), .obs2(d_obs2),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err_v[0]),
    .fail_vld(fvld_v[0]), .fail_sel(fsel_v[0]), .fail_ch(fch_v[0])
  );

  condition_sweep_checker #(.CH_MASK(3'b001)) u_mask (
    .clk(clk), .rst(rst), .start(start), .sel(sel_v[1]),
    .obs0(m_obs0), .obs1(m_obs1), .obs2(m_obs2),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err_v[1]),
    .fail_vld(fvld_v[1]), .fail_sel(fsel_v[1]), .fail_ch(fch_v[1])
  );

  condition_sweep_checker #(.SETTLE_CYC(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start), .sel(sel_v[2]),
    .obs0(s_obs0), .obs1(s_obs1), .obs2(s_obs2),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_cnt(err_v[2]),
    .fail_vld(fvld_v[2]), .fail_sel(fsel_v[2]), .fail_ch(fch_v[2])
  );

  typedef struct {
    string name;
    int    inst;
    int    mode;
    bit    dly2;
    int    exp_done;
    int    exp_pass;
    int    exp_err;
    int    exp_fvld;
    int    exp_fsel;
    int    exp_fch;
  } vec_t;

  vec_t vecs [6];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Caller sits 1 time unit after a rising edge; returns 1 unit after edge t+1.
  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Observes cycles t+1..t+40, optionally checking the sel/busy sequence of a
  // default-parameter sweep and re-asserting start so it is sampled at edge restart_k+1.
  task automatic run_sweep(input int inst, input bit chk_seq, input int restart_k,
                           output int done_k, output int done_n);
    done_k = -1;
    done_n = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done_v[inst]) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (chk_seq && k <= 24) chk($sformatf("sel@t+%0d", k), int'(sel_v[inst]), ((k - 1) / 3) % 4);
      if (chk_seq && k <= 25) chk($sformatf("busy@t+%0d", k), int'(busy_v[inst]), (k <= 24) ? 1 : 0);
      start = (k == restart_k);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel"},  int'(sel_v[0]),  0);
    chk({tag, "_busy"}, int'(busy_v[0]), 0);
    chk({tag, "_done"}, int'(done_v[0]), 0);
    chk({tag, "_pass"}, int'(pass_v[0]), 0);
    chk({tag, "_err"},  int'(err_v[0]),  0);
    chk({tag, "_fvld"}, int'(fvld_v[0]), 0);
    chk({tag, "_fsel"}, int'(fsel_v[0]), 0);
    chk({tag, "_fch"},  int'(fch_v[0]),  0);
  endtask

  initial begin
    int dk, dn;
    vecs[0] = '{"identity",  0, 0, 1'b0, 25, 1, 0,  0, 0, 0};
    vecs[1] = '{"stuck_ch1", 0, 1, 1'b0, 25, 0, 6,  1, 1, 1};
    vecs[2] = '{"saturate",  0, 2, 1'b0, 25, 0, 15, 1, 0, 0};
    vecs[3] = '{"mask",      1, 0, 1'b0, 25, 1, 0,  0, 0, 0};
    vecs[4] = '{"settle_d1", 2, 0, 1'b0, 17, 1, 0,  0, 0, 0};
    vecs[5] = '{"settle_d2", 2, 0, 1'b1, 17, 0, 8,  1, 0, 0};

    rst = 1'b1; start = 1'b0; mode = 0; dly2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      dly2 = vecs[i].dly2;
      start_pulse();
      run_sweep(vecs[i].inst, (i == 0), 0, dk, dn);
      chk({vecs[i].name, "_done_at"}, dk, vecs[i].exp_done);
      chk({vecs[i].name, "_done_n"},  dn, 1);
      chk({vecs[i].name, "_pass"}, int'(pass_v[vecs[i].inst]), vecs[i].exp_pass);
      chk({vecs[i].name, "_err"},  int'(err_v[vecs[i].inst]),  vecs[i].exp_err);
      chk({vecs[i].name, "_fvld"}, int'(fvld_v[vecs[i].inst]), vecs[i].exp_fvld);
      chk({vecs[i].name, "_fsel"}, int'(fsel_v[vecs[i].inst]), vecs[i].exp_fsel);
      chk({vecs[i].name, "_fch"},  int'(fch_v[vecs[i].inst]),  vecs[i].exp_fch);
    end

    // start re-pulsed mid-sweep (sampled at t+5) must be ignored
    mode = 0;
    dly2 = 1'b0;
    start_pulse();
    run_sweep(0, 1'b1, 4, dk, dn);
    chk("restart_done_at", dk, 25);
    chk("restart_done_n", dn, 1);
    chk("restart_pass", int'(pass_v[0]), 1);

    // reset at t+10 in the middle of a failing sweep
    mode = 1;
    start_pulse();
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_err", int'(err_v[0]), 1);
    chk("pre_rst_fsel", int'(fsel_v[0]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_vals("mid_rst");
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_v[0]) dn++;
      @(posedge clk);
      #1;
    end
    chk("post_rst_no_done", dn, 0);

    mode = 0;
    start_pulse();
    run_sweep(0, 1'b0, 0, dk, dn);
    chk("fresh_done_at", dk, 25);
    chk("fresh_pass", int'(pass_v[0]), 1);
    chk("fresh_err", int'(err_v[0]), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/condition_sweep_checker.md
# condition_sweep_checker

Self-checking sweep engine for 2-bit select-driven condition logic. On `start` it drives `sel` through 0..3 for `ROUNDS` passes. After each change it waits `SETTLE_CYC` cycles, then compares up to three observed 2-bit result channels against a golden lookup table. It counts mismatches, records the first failure, and reports pass/fail, so the sweep-and-observe job runs in synthesizable logic next to the condition blocks.

## Interface
- `SETTLE_CYC`, 2: cycles `sel` is held before sampling; legal range 1..15.
- `ROUNDS`, 2: number of full 0..3 sweeps; legal range 1..4. Total checks = 4*`ROUNDS`.
- `EXP_TABLE`, 8'hE4: golden values; `EXP_TABLE[2k+1:2k]` is the expected result for `sel`=k. The default is identity.
- `CH_MASK`, 3'b111: bit i enables the comparison of `obs`i.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a sweep; sampled only in IDLE.
- `sel`  out  2  select driven to the logic under check.
- `obs0`, `obs1`, `obs2`  in  2 each  observed results, combinational from `sel`.
- `busy`  out  1  high from the cycle after `start` is accepted through the last CHECK.
- `done`  out  1  one-cycle pulse at sweep end.
- `pass`  out  1  1 when the last sweep had zero mismatches; held until the next `start`.
- `err_cnt`  out  4  mismatch count, saturating at 15.
- `fail_vld`  out  1  a first failure has been captured.
- `fail_sel`  out  2  `sel` value at the first failure.
- `fail_ch`  out  2  lowest-index failing channel at the first failure.

## Operation
- Reset values: `sel`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vld`=0, `fail_sel`=0, `fail_ch`=0; state is IDLE.
- States are IDLE, SETTLE, CHECK and DONE.
- IDLE:
  - `start`=1 → go to SETTLE.
  - On entry to SETTLE: `sel`=0, step counter=0, settle counter=`SETTLE_CYC`-1.
  - Also clear `err_cnt`, `fail_*` and `pass`.
- SETTLE:
  - Stays exactly `SETTLE_CYC` cycles, counting the settle counter down to 0, then goes to CHECK.
- CHECK:
  - Lasts one cycle. For each enabled channel i, a mismatch is `obs`i != `EXP_TABLE` entry[`sel`].
  - `err_cnt` += number of mismatches (0..3), saturating at 15.
  - If there is any mismatch and `fail_vld`=0: set `fail_vld`=1, `fail_sel`=`sel`, `fail_ch`=lowest mismatching enabled index.
  - If step = 4*`ROUNDS`-1: go to DONE.
  - Otherwise: step+1, `sel`+1 (wraps 3→0 between rounds), reload the settle counter, go to SETTLE.
- DONE:
  - Lasts one cycle; `done`=1 and `busy`=0.
  - `pass` = (final `err_cnt`==0), which must include any mismatch found in the last CHECK.
  - Then IDLE; `sel` returns to 0.
- Ignored inputs: `start` in SETTLE, CHECK or DONE.
- Held values: `err_cnt`, `fail_*` and `pass` hold after DONE until the next accepted `start`.
- `rst`=1 in any state: all outputs go to reset values at that edge, and any sweep in progress is abandoned.
- Channels disabled in `CH_MASK` never contribute, whatever their value.

## Timing
- Edge numbering: `start` is sampled high in IDLE at edge t.
- `busy`=1 and `sel`=0 from t+1.
- Each step occupies `SETTLE_CYC`+1 cycles: `SETTLE_CYC` in SETTLE, then 1 in CHECK.
- Comparison timing: it uses the `obs` values present during the CHECK cycle. That cycle is the (`SETTLE_CYC`+1)th cycle with the current `sel` value.
- `sel` changes at the edge that leaves CHECK.
- `done` pulses in cycle t+1+4*`ROUNDS`*(`SETTLE_CYC`+1). With the defaults this is t+25, after 24 busy cycles.
- Next start: the earliest next `start` is accepted at the edge after DONE.
- Register update point: `err_cnt` and `fail_*` update at the edge ending CHECK.

## Test plan
- **Identity pass:** defaults; drive `obs0`=`obs1`=`obs2`=`sel`; pulse `start` → `sel` sequence 0,1,2,3,0,1,2,3, each held 3 cycles; `done` at t+25; `pass`=1, `err_cnt`=0, `fail_vld`=0.
- **Stuck channel:** `obs1` tied to 0, other channels correct → `err_cnt`=6, `fail_vld`=1, `fail_sel`=1, `fail_ch`=1, `pass`=0.
- **Saturation:** all channels = ~`sel` → 24 raw mismatches → `err_cnt`=15, `fail_sel`=0, `fail_ch`=0, `pass`=0.
- **Mask:** `CH_MASK`=3'b001, `obs0`=`sel`, `obs1`/`obs2` random → `pass`=1, `err_cnt`=0.
- **Settle window:**
  - `SETTLE_CYC`=1, `obs0` = `sel` registered once (1-cycle delay) → `pass`=1.
  - Same setup with a 2-cycle delay → every check fails: `err_cnt`=8, `fail_sel`=0.
- **Reset and start masking:**
  - Re-pulse `start` at t+5 → ignored; `done` still at t+25.
  - Separately, assert `rst` at t+10 → next cycle all outputs are at reset values, and no `done` follows.
  - A fresh `start` then completes a normal sweep.
